// File: rtl/xswitch_pkg.sv
// xswitch_pkg: definitions shared by the xswitch endpoints.
// Contents: port count, default widths, the stream word layout, the sink
// control-state encoding and helpers that split an address into source and
// destination port fields.
package xswitch_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int PORT_W     = 4;

  // One buffered transfer; the FIFO word uses the same {addr, data} layout.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } stream_word_t;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_FULL   = 1'b1
  } sink_state_e;

  function automatic logic [PORT_W-1:0] src_of(input logic [ADDR_W_DEF-1:0] addr);
    return addr[7:4];
  endfunction

  function automatic logic [PORT_W-1:0] dst_of(input logic [ADDR_W_DEF-1:0] addr);
    return addr[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with power-of-two depth.
// Ports:
//   clk, reset       rising-edge clock, async active-high reset (drops contents)
//   push, wdata      write wdata this edge (ignored when full)
//   pop              advance the head this edge (ignored when empty)
//   rdata            current head entry (valid while !empty)
//   full, empty      occupancy decodes
//   count            occupancy, 0..DEPTH
module sync_fifo
  import xswitch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_BITS-1:0] count_r;
  logic                push_s;
  logic                pop_s;

  assign full   = (count_r == CNT_BITS'(DEPTH));
  assign empty  = (count_r == {CNT_BITS{1'b0}});
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Pointer and occupancy state; pointers wrap naturally because DEPTH is 2**PTR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_BITS{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_BITS'(1);
        2'b01:   count_r <= count_r - CNT_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; not reset since the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/upstream_sink.sv
// upstream_sink: consuming end of one xswitch output stream.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   us_valid/us_data/us_addr   transfer from the switch ({src, dst} address)
//   us_ready                   sink can accept (registered-state decode only)
//   drain_en                   consumer pops one entry when the FIFO is non-empty
//   pop_valid/pop_data/pop_addr registered popped entry, pop_valid pulses one cycle
//   pkt_count                  saturating per-source counters, source i at [i*CNT_W +: CNT_W]
//   err_dst, err_src           sticky address-error flags
//   clear_stats                synchronous clear of counters and flags
module upstream_sink
  import xswitch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = NUM_PORTS,
  parameter int CNT_W   = 16,
  parameter int MY_PORT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     us_valid,
  input  logic [DATA_W-1:0]        us_data,
  input  logic [ADDR_W-1:0]        us_addr,
  output logic                     us_ready,
  input  logic                     drain_en,
  output logic                     pop_valid,
  output logic [DATA_W-1:0]        pop_data,
  output logic [ADDR_W-1:0]        pop_addr,
  output logic [NUM_SRC*CNT_W-1:0] pkt_count,
  output logic                     err_dst,
  output logic                     err_src,
  input  logic                     clear_stats
);

  localparam int CNT_BITS = $clog2(DEPTH) + 1;
  localparam int WORD_W   = ADDR_W + DATA_W;

  sink_state_e         state_r;
  sink_state_e         state_nx_s;
  logic [WORD_W-1:0]   head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_BITS-1:0] count_s;
  logic                push_s;
  logic                pop_s;
  logic [PORT_W-1:0]   src_s;
  logic [PORT_W-1:0]   dst_s;
  logic [CNT_W-1:0]    cnt_r [NUM_SRC];
  logic                err_dst_r;
  logic                err_src_r;

  assign us_ready = (state_r == ST_ACCEPT);
  // The full term is redundant with the state decode; it keeps a corrupted
  // state register from ever overwriting a live entry.
  assign push_s   = us_valid && us_ready && !fifo_full_s;
  assign pop_s    = drain_en && !fifo_empty_s;
  assign src_s    = src_of(us_addr);
  assign dst_s    = dst_of(us_addr);
  assign err_dst  = err_dst_r;
  assign err_src  = err_src_r;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({us_addr, us_data}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s)
  );

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_out
    assign pkt_count[g*CNT_W +: CNT_W] = cnt_r[g];
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_ACCEPT;
    else       state_r <= state_nx_s;
  end

  // Next state: enter FULL on a push-only edge that fills the last slot, leave on any pop.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_ACCEPT: begin
        if (push_s && !pop_s && (count_s == CNT_BITS'(DEPTH - 1))) state_nx_s = ST_FULL;
        else                                                      state_nx_s = ST_ACCEPT;
      end
      ST_FULL: begin
        if (pop_s) state_nx_s = ST_ACCEPT;
        else       state_nx_s = ST_FULL;
      end
      default: state_nx_s = ST_ACCEPT;
    endcase
  end

  // Pop output registers; data/addr hold their last value between pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_valid <= 1'b0;
      pop_data  <= {DATA_W{1'b0}};
      pop_addr  <= {ADDR_W{1'b0}};
    end else if (pop_s) begin
      pop_valid <= 1'b1;
      pop_data  <= head_s[DATA_W-1:0];
      pop_addr  <= head_s[DATA_W +: ADDR_W];
    end else begin
      pop_valid <= 1'b0;
    end
  end

  // Statistics; clear_stats wins over a same-edge transfer, which is then not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_r[i] <= {CNT_W{1'b0}};
      err_dst_r <= 1'b0;
      err_src_r <= 1'b0;
    end else if (clear_stats) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_r[i] <= {CNT_W{1'b0}};
      err_dst_r <= 1'b0;
      err_src_r <= 1'b0;
    end else if (push_s) begin
      if (int'(src_s) < NUM_SRC) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if ((int'(src_s) == i) && (cnt_r[i] != {CNT_W{1'b1}})) cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end else begin
        err_src_r <= 1'b1;
      end
      if (dst_s != PORT_W'(MY_PORT)) err_dst_r <= 1'b1;
    end
  end

endmodule
